// File: rtl/alu_sequencer.sv
// Multi-cycle ALU front end: single-cycle ops go through the ALU datapath,
// multiply runs as an iterative unsigned shift-and-add over SIZE cycles.
module alu_sequencer #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      operation,
  input  logic [SIZE-1:0] op1,
  input  logic [SIZE-1:0] op2,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [SIZE-1:0] result,
  output logic            zero,
  output logic            overflow,
  output logic            busy
);

  localparam int CW = $clog2(SIZE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [2:0]        r_op;
  logic [SIZE-1:0]   r_a;
  logic [SIZE-1:0]   r_b;
  logic [SIZE-1:0]   r_mplier;
  logic [2*SIZE-1:0] r_acc;
  logic [2*SIZE-1:0] r_mcand;
  logic [CW-1:0]     r_count;
  logic [SIZE-1:0]   r_result;
  logic              r_zero;
  logic              r_ovf;

  logic [SIZE-1:0]   w_neg_b;
  logic [SIZE:0]     w_sum;
  logic [SIZE:0]     w_diff;
  logic [SIZE-1:0]   w_alu_res;
  logic              w_alu_ovf;
  logic [2*SIZE-1:0] w_acc_next;

  // Subtraction carry uses the SIZE-bit two's complement, so op2 == 0 yields no carry.
  always_comb begin
    w_neg_b   = '0 - r_b;
    w_sum     = {1'b0, r_a} + {1'b0, r_b};
    w_diff    = {1'b0, r_a} + {1'b0, w_neg_b};
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (r_op)
      3'b000: begin
        w_alu_res = w_sum[SIZE-1:0];
        w_alu_ovf = w_sum[SIZE];
      end
      3'b001: begin
        w_alu_res = w_diff[SIZE-1:0];
        w_alu_ovf = w_diff[SIZE];
      end
      3'b011:  w_alu_res = r_a & r_b;
      3'b100:  w_alu_res = r_a | r_b;
      3'b101:  w_alu_res = ~r_a;
      default: w_alu_res = '0;
    endcase
  end

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_op <= operation;
            r_a  <= op1;
            r_b  <= op2;
            if (operation == 3'b010) begin
              r_acc    <= '0;
              r_mcand  <= {{SIZE{1'b0}}, op1};
              r_mplier <= op2;
              r_count  <= '0;
              r_state  <= S_MUL;
            end else begin
              r_state  <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_result <= w_alu_res;
          r_ovf    <= w_alu_ovf;
          r_zero   <= (w_alu_res == '0);
          r_state  <= S_DONE;
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          // Last step: publish from the updated accumulator, not the stale one.
          if (r_count == CW'(SIZE - 1)) begin
            r_result <= w_acc_next[SIZE-1:0];
            r_ovf    <= |w_acc_next[2*SIZE-1:SIZE];
            r_zero   <= (w_acc_next[SIZE-1:0] == '0);
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (result_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_ready  = (r_state == S_IDLE);
  assign result_valid = (r_state == S_DONE);
  assign busy         = (r_state != S_IDLE);
  assign result       = r_result;
  assign zero         = r_zero;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: arithmetic reference model compared
// every cycle, plus literal expectations on directed cases.
module tb_alu_sequencer;

  localparam int SIZE = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_valid = 1'b0;
  logic        result_ready = 1'b0;
  logic [2:0]  operation = 3'b000;
  logic [15:0] op1 = 16'h0000;
  logic [15:0] op2 = 16'h0000;
  logic        start_ready;
  logic        result_valid;
  logic [15:0] result;
  logic        zero;
  logic        overflow;
  logic        busy;

  alu_sequencer #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .operation(operation), .op1(op1), .op2(op2),
    .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .zero(zero), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the unsigned flag rules.
  function automatic void ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic o);
    longint unsigned full;
    r = 16'h0;
    o = 1'b0;
    full = 0;
    case (op)
      3'd0: begin full = a; full = full + b; r = full[15:0]; o = (full >= 65536); end
      3'd1: begin r = a - b; o = (a >= b) && (b != 0); end
      3'd2: begin full = a; full = full * b; r = full[15:0]; o = (full >= 65536); end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = ~a;
      default: r = 16'h0;
    endcase
  endfunction

  // Model: idle / waiting a fixed number of edges / holding a result.
  bit          m_idle = 1'b1;
  bit          m_done = 1'b0;
  int          m_wait = 0;
  logic [15:0] m_res = 16'h0, m_pres = 16'h0;
  logic        m_z = 1'b0, m_o = 1'b0, m_po = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_idle = 1'b1; m_done = 1'b0; m_wait = 0;
      m_res = 16'h0; m_z = 1'b0; m_o = 1'b0;
    end else if (m_idle) begin
      if (start_valid) begin
        ref_op(operation, op1, op2, m_pres, m_po);
        m_wait = (operation == 3'd2) ? SIZE : 1;
        m_idle = 1'b0;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_done = 1'b1;
        m_res = m_pres; m_o = m_po; m_z = (m_pres == 16'h0);
      end
    end else if (m_done && result_ready) begin
      m_done = 1'b0;
      m_idle = 1'b1;
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("start_ready", start_ready, m_idle);
      chk("busy", busy, !m_idle);
      chk("result_valid", result_valid, m_done);
      chk("result", result, m_res);
      chk("zero", zero, m_z);
      chk("overflow", overflow, m_o);
    end
  end

  task automatic idle(input int n);
    @(negedge clk); #2;
    start_valid = 1'b0;
    result_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request end to end; leaves result_ready=1 just after the release edge.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int bp,
                       output int lat, output logic [15:0] r, output logic z, output logic o);
    @(negedge clk); #2;
    start_valid = 1'b1; result_ready = 1'b0;
    operation = op; op1 = a; op2 = b;
    @(posedge clk); #1;
    chk("accepted", busy, 1'b1);
    @(negedge clk); #2;
    start_valid = 1'b0;
    operation = 3'($urandom); op1 = 16'($urandom); op2 = 16'($urandom);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (result_valid) break;
    end
    chk("valid_within_bound", result_valid, 1'b1);
    r = result; z = zero; o = overflow;
    chk("latency", lat, (op == 3'd2) ? SIZE : 1);
    if (bp > 0) begin
      @(negedge clk); #2;
      start_valid = 1'b1;
      operation = 3'($urandom); op1 = 16'($urandom); op2 = 16'($urandom);
      repeat (bp) @(posedge clk);
      #1;
      chk("bp_start_ready", start_ready, 1'b0);
      chk("bp_result_held", result, r);
    end
    @(negedge clk); #2;
    result_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_start_ready", start_ready, 1'b1);
  endtask

  int          lat;
  logic [15:0] r;
  logic        z, o;

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_ready", start_ready, 1'b1);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 16'h0);
    chk("rst_flags", {zero, overflow}, 2'b00);

    issue(3'd0, 16'hFFFF, 16'h0001, 0, lat, r, z, o);
    chk("add_res", r, 16'h0000); chk("add_flags", {z, o}, 2'b11);

    issue(3'd1, 16'd5, 16'd3, 5, lat, r, z, o);
    chk("sub53_res", r, 16'h0002); chk("sub53_flags", {z, o}, 2'b01);
    issue(3'd1, 16'd3, 16'd5, 0, lat, r, z, o);
    chk("sub35_res", r, 16'hFFFE); chk("sub35_flags", {z, o}, 2'b00);
    issue(3'd1, 16'd7, 16'd0, 0, lat, r, z, o);
    chk("sub70_res", r, 16'h0007); chk("sub70_flags", {z, o}, 2'b00);

    issue(3'd2, 16'd300, 16'd200, 0, lat, r, z, o);
    chk("mul_res", r, 16'hEA60); chk("mul_flags", {z, o}, 2'b00);
    issue(3'd2, 16'h0100, 16'h0100, 0, lat, r, z, o);
    chk("mulsq_res", r, 16'h0000); chk("mulsq_flags", {z, o}, 2'b11);
    issue(3'd2, 16'hFFFF, 16'h0001, 0, lat, r, z, o);
    chk("mul1_res", r, 16'hFFFF); chk("mul1_flags", {z, o}, 2'b00);

    // Abort a multiply with reset during its 8th cycle.
    idle(1);
    @(negedge clk); #2;
    start_valid = 1'b1; operation = 3'd2; op1 = 16'd300; op2 = 16'd200;
    @(posedge clk);
    @(negedge clk); #2;
    start_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b1;
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("abort_start_ready", start_ready, 1'b1);
    chk("abort_result", result, 16'h0);
    chk("abort_flags", {zero, overflow}, 2'b00);
    begin
      int seen = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (result_valid) seen++;
      end
      chk("abort_no_valid", seen, 0);
    end
    issue(3'd3, 16'h0F0F, 16'h00FF, 0, lat, r, z, o);
    chk("and_res", r, 16'h000F); chk("and_flags", {z, o}, 2'b00);

    issue(3'd5, 16'hFFFF, 16'h1234, 0, lat, r, z, o);
    chk("not_res", r, 16'h0000); chk("not_flags", {z, o}, 2'b10);
    issue(3'd6, 16'h1234, 16'h5678, 0, lat, r, z, o);
    chk("op6_res", r, 16'h0000); chk("op6_flags", {z, o}, 2'b10);
    issue(3'd7, 16'hABCD, 16'hFFFF, 0, lat, r, z, o);
    chk("op7_res", r, 16'h0000); chk("op7_flags", {z, o}, 2'b10);

    for (int i = 0; i < 200; i++) begin
      logic [15:0] a, b;
      case ($urandom_range(0, 3))
        0: a = 16'h0000;
        1: a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: b = 16'h0000;
        1: b = 16'($urandom_range(0, 3));
        default: b = 16'($urandom);
      endcase
      issue(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 3), lat, r, z, o);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
